muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Sequences the shared Mult and Div units on behalf of the main Control FSM.
//  It accepts one MULT/DIV request and launches the selected unit, then waits for its end flag.
//  It then commits the result into Hi/Lo via SrcHiLo/HiLoWrite and reports done or an exception.
//  Sits between Control and the Mult/Div/Hi/Lo datapath; Control stalls while busy=1.
// PARAMETERS
//  TIMEOUT_CYCLES  40  max WAIT cycles before abort (Mult/Div need <=33)
//  CNT_W           6   width of watchdog counter; must hold TIMEOUT_CYCLES-1
// PORTS
//  clk             in   1  system clock, rising edge
//  reset           in   1  synchronous, active-high reset
//  req             in   1  start request from Control, sampled only in IDLE
//  op              in   1  0=MULT, 1=DIV; sampled with req
//  operand_b_zero  in   1  OutB==0, sampled with req
//  mult_end        in   1  Mult finished (MultEnd)
//  div_end         in   1  Div finished (DivEnd)
//  mult_start      out  1  one-cycle launch pulse to Mult (MultControl)
//  div_start       out  1  one-cycle launch pulse to Div (DivControl)
//  src_hilo        out  1  Hi/Lo source select: 0=Mult, 1=Div (SrcHiLo)
//  hilo_write      out  1  Hi/Lo write enable (HiLoWrite)
//  busy            out  1  high in every state except IDLE
//  done            out  1  one-cycle completion pulse
//  exc_div0        out  1  one-cycle divide-by-zero exception pulse
//  exc_timeout     out  1  one-cycle watchdog exception pulse
// BEHAVIOUR
//  - Moore FSM; all outputs decode from the registered state plus the latched op.
//    States: IDLE, START, WAIT, WRITE, DONE, ERR.
//  - Reset: state=IDLE, op_q=0, cnt=0, err_q=0; all outputs 0 on the cycle after reset is sampled.
//  - Reset mid-operation aborts immediately. No hilo_write and no done are issued.
//  - IDLE: if req=1 and op=1 and operand_b_zero=1, go to ERR with err_q=DIV0 and latch op.
//    Otherwise, if req=1, latch op into op_q and go to START. If req=0, stay in IDLE.
//  - START: mult_start=~op_q, div_start=op_q for exactly this cycle; cnt<=0; go to WAIT.
//  - WAIT: cnt increments each cycle.
//    If the end flag of the selected unit is high, go to WRITE.
//    The end flag of the other unit is ignored.
//    If cnt==TIMEOUT_CYCLES-1 and no end flag is seen, go to ERR with err_q=TIMEOUT.
//    A simultaneous end flag and timeout resolves to WRITE (end wins).
//  - WRITE: hilo_write=1 for one cycle; go to DONE.
//  - DONE: done=1 for one cycle; go to IDLE.
//  - ERR: exc_div0 or exc_timeout=1 per err_q for one cycle; done=0; go to IDLE.
//  - src_hilo=op_q in START, WAIT and WRITE; 0 in IDLE, DONE and ERR.
//  - req outside IDLE is ignored; it is not queued.
//    A req held high through DONE starts a new operation from the following IDLE cycle.
//  - Timing: req sampled in cycle k gives START in k+1 and WAIT from k+2.
//    An end flag seen in WAIT cycle m gives WRITE in m+1, DONE in m+2 and IDLE in m+3.
//    Minimum req-to-done latency is 4 cycles.
//  - hilo_write is never asserted in an operation that ends in ERR.
// STRUCTURE
//  - Shared package muldiv_pkg holds:
//    - state encoding localparams (S_IDLE..S_ERR, 3 bits)
//    - OP_MULT=1'b0, OP_DIV=1'b1
//    - SRC_HILO_MULT=1'b0, SRC_HILO_DIV=1'b1
//    - ERR_DIV0 and ERR_TIMEOUT codes
//  - One sub-module, cycle_watchdog: clear/enable/expired counter parameterised by TIMEOUT_CYCLES and CNT_W.
//  - All remaining logic (FSM, op/err latches, output decode) lives in muldiv_sequencer.
// TESTING
//  1. Reset 2 cycles; req=1, op=0 at k; mult_end in cycle k+35.
//     Expect: mult_start only at k+1; hilo_write=1 with src_hilo=0 at k+36; done at k+37; busy=0 at k+38.
//  2. req=1, op=1, operand_b_zero=1 at k.
//     Expect: div_start never asserted; exc_div0=1 at k+1 only; hilo_write=0 throughout; busy=0 at k+2.
//  3. req, op=1, operand_b_zero=0, div_end never asserted, TIMEOUT_CYCLES=40.
//     Expect: exc_timeout after exactly 40 WAIT cycles; no hilo_write; no done.
//  4. MULT in progress; pulse div_end during WAIT, then mult_end 5 cycles later.
//     Expect: div_end ignored; WRITE follows mult_end only; src_hilo=0.
//  5. Pulse req during WAIT, then assert reset mid-WAIT.
//     Expect: the extra req is ignored; all outputs 0 and state IDLE the cycle after reset.
//  6. req held high continuously; mult_end/div_end respond 3 cycles after each start.
//     Expect: back-to-back operations with exactly one IDLE cycle between done and the next start.

Source files
------------

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings for the Mult/Div sequencer
package muldiv_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam logic SRC_HILO_MULT = 1'b0;
  localparam logic SRC_HILO_DIV  = 1'b1;

  typedef enum logic {
    ERR_DIV0    = 1'b0,
    ERR_TIMEOUT = 1'b1
  } err_t;

endpackage

// File: rtl/cycle_watchdog.sv
// rtl/cycle_watchdog.sv - clearable up-counter flagging the last allowed wait cycle
module cycle_watchdog #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  // Count enabled cycles; clear has priority so a fresh launch always starts at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // High during the final permitted cycle, so the caller can abort on this edge
  assign expired = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - launches Mult or Div, waits for its end flag, commits Hi/Lo
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic op,
  input  logic operand_b_zero,
  input  logic mult_end,
  input  logic div_end,
  output logic mult_start,
  output logic div_start,
  output logic src_hilo,
  output logic hilo_write,
  output logic busy,
  output logic done,
  output logic exc_div0,
  output logic exc_timeout
);

  state_t state;
  logic   op_q;
  err_t   err_q;
  logic   expired;
  logic   unit_end;

  // Only the unit that was actually launched may end the wait
  assign unit_end = (op_q == OP_DIV) ? div_end : mult_end;

  cycle_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == S_START),
    .enable (state == S_WAIT),
    .expired(expired)
  );

  // Sequencing FSM with op and error-cause latches
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      op_q  <= OP_MULT;
      err_q <= ERR_DIV0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            op_q <= op;
            if (op == OP_DIV && operand_b_zero) begin
              err_q <= ERR_DIV0;
              state <= S_ERR;
            end else begin
              state <= S_START;
            end
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          // An end flag on the final cycle still wins over the watchdog
          if (unit_end) begin
            state <= S_WRITE;
          end else if (expired) begin
            err_q <= ERR_TIMEOUT;
            state <= S_ERR;
          end
        end
        S_WRITE: state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mult_start  = (state == S_START) && (op_q == OP_MULT);
  assign div_start   = (state == S_START) && (op_q == OP_DIV);
  assign src_hilo    = ((state == S_START) || (state == S_WAIT) || (state == S_WRITE)) &&
                       (op_q == OP_DIV) ? SRC_HILO_DIV : SRC_HILO_MULT;
  assign hilo_write  = (state == S_WRITE);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign exc_div0    = (state == S_ERR) && (err_q == ERR_DIV0);
  assign exc_timeout = (state == S_ERR) && (err_q == ERR_TIMEOUT);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

  localparam int TO = 40;

  logic clk, reset, req, op, operand_b_zero, mult_end, div_end;
  logic mult_start, div_start, src_hilo, hilo_write, busy, done, exc_div0, exc_timeout;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  muldiv_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .operand_b_zero(operand_b_zero),
    .mult_end(mult_end), .div_end(div_end), .mult_start(mult_start), .div_start(div_start),
    .src_hilo(src_hilo), .hilo_write(hilo_write), .busy(busy), .done(done),
    .exc_div0(exc_div0), .exc_timeout(exc_timeout)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Event records observed on the falling edge
  int n_ms = 0, n_ds = 0, n_hw = 0, n_done = 0, n_d0 = 0, n_to = 0;
  int last_ms = -1, last_ds = -1, last_hw = -1, last_done = -1, last_d0 = -1, last_to = -1;
  logic last_hw_src = 0;
  int start_q[$];
  int done_q[$];
  int resp_cyc = -1;
  logic resp_div = 0;

  // Transaction-level model: tracks elapsed cycles since a request was accepted
  bit m_known = 0, m_act = 0, m_op = 0, m_div0 = 0;
  int m_t = 0, m_end_t = 0;

  initial forever begin
    logic [7:0] e, a;
    bit last;
    @(negedge clk);
    e = '0;  // {ms, ds, src, hw, busy, done, d0, to}
    if (m_act) begin
      e[3] = 1;
      if (m_div0) e[1] = 1;
      else if (m_t == 1) begin e[7] = !m_op; e[6] = m_op; e[5] = m_op; end
      else if (m_end_t == 0) begin
        if (m_t == TO + 2) e[0] = 1; else e[5] = m_op;
      end
      else if (m_t == m_end_t + 1) begin e[4] = 1; e[5] = m_op; end
      else e[2] = 1;
    end
    a = {mult_start, div_start, src_hilo, hilo_write, busy, done, exc_div0, exc_timeout};
    if (m_known) begin
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_outputs cyc=%0d got=%b expected=%b", cyc, a, e);
      end
    end
    if (mult_start) begin n_ms++; last_ms = cyc; start_q.push_back(cyc); resp_cyc = cyc + 3; resp_div = 0; end
    if (div_start)  begin n_ds++; last_ds = cyc; start_q.push_back(cyc); resp_cyc = cyc + 3; resp_div = 1; end
    if (hilo_write) begin n_hw++; last_hw = cyc; last_hw_src = src_hilo; end
    if (done)       begin n_done++; last_done = cyc; done_q.push_back(cyc); end
    if (exc_div0)   begin n_d0++; last_d0 = cyc; end
    if (exc_timeout) begin n_to++; last_to = cyc; end
    if (reset) begin
      m_known = 1;
      m_act = 0;
    end else if (m_known) begin
      if (!m_act) begin
        if (req) begin
          m_act = 1; m_t = 1; m_op = op; m_div0 = op && operand_b_zero; m_end_t = 0;
        end
      end else begin
        last = m_div0 || (m_end_t == 0 && m_t == TO + 2) || (m_end_t != 0 && m_t == m_end_t + 2);
        if (!m_div0 && m_end_t == 0 && m_t >= 2 && m_t <= TO + 1 && (m_op ? div_end : mult_end))
          m_end_t = m_t;
        if (last) m_act = 0; else m_t++;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic launch(input logic o, input logic bz, output int k);
    step();
    req = 1; op = o; operand_b_zero = bz;
    k = cyc;
    step();
    req = 0;
  endtask

  initial begin
    int k, b_ms, b_ds, b_hw, b_done, b_d0, b_to;
    reset = 0; req = 0; op = 0; operand_b_zero = 0; mult_end = 0; div_end = 0;

    // 1: reset then MULT finishing after 33 wait cycles
    step(); reset = 1;
    step();
    step(); reset = 0;
    step();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    b_ms = n_ms; b_hw = n_hw;
    launch(0, 0, k);
    run_until(k + 35); mult_end = 1;
    step(); mult_end = 0;
    run_until(k + 40);
    check("t1_start_cyc", last_ms, k + 1);
    check("t1_start_cnt", n_ms - b_ms, 1);
    check("t1_write_cyc", last_hw, k + 36);
    check("t1_write_src", last_hw_src, 0);
    check("t1_write_cnt", n_hw - b_hw, 1);
    check("t1_done_cyc", last_done, k + 37);

    // 2: divide by zero
    b_ds = n_ds; b_hw = n_hw; b_d0 = n_d0; b_done = n_done;
    launch(1, 1, k);
    run_until(k + 6);
    check("t2_div0_cyc", last_d0, k + 1);
    check("t2_div0_cnt", n_d0 - b_d0, 1);
    check("t2_no_div_start", n_ds - b_ds, 0);
    check("t2_no_write", n_hw - b_hw, 0);
    check("t2_no_done", n_done - b_done, 0);

    // 3: DIV timeout while the Mult end flag is stuck high
    b_hw = n_hw; b_to = n_to; b_done = n_done;
    operand_b_zero = 0;
    launch(1, 0, k);
    mult_end = 1;
    run_until(k + 46);
    mult_end = 0;
    check("t3_timeout_cyc", last_to, k + TO + 2);
    check("t3_timeout_cnt", n_to - b_to, 1);
    check("t3_no_write", n_hw - b_hw, 0);
    check("t3_no_done", n_done - b_done, 0);

    // 4: MULT ignores a div_end pulse
    launch(0, 0, k);
    run_until(k + 5); div_end = 1;
    step(); div_end = 0;
    run_until(k + 10); mult_end = 1;
    step(); mult_end = 0;
    run_until(k + 15);
    check("t4_write_cyc", last_hw, k + 11);
    check("t4_write_src", last_hw_src, 0);

    // 5: stray req in WAIT, then reset mid-WAIT
    b_ms = n_ms; b_hw = n_hw; b_done = n_done;
    launch(0, 0, k);
    run_until(k + 4); req = 1;
    step(); req = 0;
    run_until(k + 8); reset = 1;
    step(); reset = 0;
    check("t5_busy_after_reset", busy, 0);
    check("t5_write_after_reset", hilo_write, 0);
    run_until(k + 14);
    check("t5_start_cnt", n_ms - b_ms, 1);
    check("t5_no_write", n_hw - b_hw, 0);
    check("t5_no_done", n_done - b_done, 0);

    // 6: req held high, units respond 3 cycles after each start
    start_q.delete(); done_q.delete();
    step();
    req = 1; op = 0; k = cyc;
    while (cyc < k + 40) begin
      step();
      if (cyc == k + 30) req = 0;
      mult_end = (cyc == resp_cyc) && !resp_div;
      div_end  = (cyc == resp_cyc) && resp_div;
    end
    mult_end = 0; div_end = 0;
    if (start_q.size() >= 3 && done_q.size() >= 1) begin
      check("t6_first_start", start_q[0], k + 1);
      check("t6_period_a", start_q[1] - start_q[0], 7);
      check("t6_period_b", start_q[2] - start_q[1], 7);
      check("t6_done_to_start", start_q[1] - done_q[0], 2);
    end else begin
      check("t6_op_count", start_q.size(), 5);
    end

    // 7: end flag on the last permitted WAIT cycle wins over timeout
    b_to = n_to;
    launch(0, 0, k);
    run_until(k + TO + 1); mult_end = 1;
    step(); mult_end = 0;
    run_until(k + TO + 6);
    check("t7_write_cyc", last_hw, k + TO + 2);
    check("t7_no_timeout", n_to - b_to, 0);

    // 8: minimum latency DIV with end on the first WAIT cycle
    launch(1, 0, k);
    run_until(k + 2); div_end = 1;
    step(); div_end = 0;
    run_until(k + 8);
    check("t8_done_cyc", last_done, k + 4);
    check("t8_write_src", last_hw_src, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
